// File: rtl/display_7seg_mux_pkg.sv
// display_pkg: shared constants, the display buffer type and the hex
// 7-segment decoder used by display_7seg_mux.
// Optional macro DISPLAY_BLINK_EN adds a per-digit blink mask to the buffer.
package display_pkg;

   localparam int NUM_DIG = 8;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // One complete display image; held twice (pending and active).
   typedef struct packed {
      logic [4*NUM_DIG-1:0] digits;
      logic [NUM_DIG-1:0]   digit_en;
      logic [NUM_DIG-1:0]   dp;
`ifdef DISPLAY_BLINK_EN
      logic [NUM_DIG-1:0]   blink;
`endif
   } disp_buf_t;

   // Hex digit to active-low {a,b,c,d,e,f,g}.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return ~s;
   endfunction

endpackage

// File: rtl/display_7seg_mux_if.sv
// display_7seg_mux_if: producer-to-display data path.
//   master (timer side): drives digits, digit_en, dp, [blink], update;
//                        observes pending, frame_sync.
//   slave  (display)   : the reverse.
// Optional macro DISPLAY_BLINK_EN adds the blink mask.
interface display_7seg_mux_if;
   import display_pkg::*;

   logic [4*NUM_DIG-1:0] digits;
   logic [NUM_DIG-1:0]   digit_en;
   logic [NUM_DIG-1:0]   dp;
`ifdef DISPLAY_BLINK_EN
   logic [NUM_DIG-1:0]   blink;
`endif
   logic                 update;
   logic                 pending;
   logic                 frame_sync;

   modport master (
      output digits, digit_en, dp,
`ifdef DISPLAY_BLINK_EN
      output blink,
`endif
      output update,
      input  pending, frame_sync
   );

   modport slave (
      input  digits, digit_en, dp,
`ifdef DISPLAY_BLINK_EN
      input  blink,
`endif
      input  update,
      output pending, frame_sync
   );

endinterface

// File: rtl/display_7seg_mux_scan_div.sv
// scan_div: terminal-count divider. Counts 0..TC-1 and raises tick for the
// single cycle in which the count sits at TC-1.
//   clock, reset : system clock, synchronous active-high reset
//   tick         : one-cycle pulse every TC cycles
module scan_div #(
   parameter int TC = 4
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TC < 2) ? 1 : $clog2(TC);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TC - 1));

   always_ff @(posedge clock) begin
      if (reset)     cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   // A terminal count below 2 would leave no lit cycle between blanking gaps.
   always_ff @(posedge clock)
      if (!reset) assert (TC >= 2) else $error("scan_div: TC=%0d must be >= 2", TC);

endmodule

// File: rtl/display_7seg_mux.sv
// display_7seg_mux: scans eight hex digits onto a multiplexed 7-segment
// display. New data is captured into a pending buffer on update and only
// copied to the active buffer at the frame boundary (index 7 -> 0), so a
// frame never mixes old and new digits.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : slave side of display_7seg_mux_if (data in, pending/frame_sync out)
//   an           : anode selects, active low
//   dec_cat      : cathodes {a..g,dp}, active low
// Optional macro DISPLAY_BLINK_EN adds per-digit blink (BLINK_CONT period).
module display_7seg_mux
   import display_pkg::*;
#(
   parameter int SCAN_CONT  = 50000
`ifdef DISPLAY_BLINK_EN
   , parameter int BLINK_CONT = 25_000_000
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   display_7seg_mux_if.slave    bus,
   output logic [NUM_DIG-1:0]   an,
   output logic [7:0]           dec_cat
);

   logic       scan_tick, boundary, pend_q, fs_q, lit, blank_blink;
   logic [2:0] idx;
   disp_buf_t  cap_buf, pend_buf, act_buf;
   logic [3:0] nib;
   logic [7:0] an_nx, dc_nx;

   scan_div #(.TC(SCAN_CONT)) u_scan (.clock(clock), .reset(reset), .tick(scan_tick));

   assign boundary = scan_tick && (idx == 3'd7);

   always_comb begin
      cap_buf          = '0;
      cap_buf.digits   = bus.digits;
      cap_buf.digit_en = bus.digit_en;
      cap_buf.dp       = bus.dp;
`ifdef DISPLAY_BLINK_EN
      cap_buf.blink    = bus.blink;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx      <= '0;
         pend_buf <= '0;
         act_buf  <= '0;
         pend_q   <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         fs_q <= boundary;
         if (scan_tick) idx <= idx + 3'd1;
         if (boundary && pend_q) act_buf <= pend_buf;
         // A capture on the boundary edge still wins: old data commits above,
         // the new data becomes the next pending image.
         if (bus.update) begin
            pend_buf <= cap_buf;
            pend_q   <= 1'b1;
         end else if (boundary) begin
            pend_q   <= 1'b0;
         end
      end
   end

   assign bus.pending    = pend_q;
   assign bus.frame_sync = fs_q;

`ifdef DISPLAY_BLINK_EN
   logic blink_tick, phase_q;

   scan_div #(.TC(BLINK_CONT)) u_blink (.clock(clock), .reset(reset), .tick(blink_tick));

   always_ff @(posedge clock) begin
      if (reset)           phase_q <= 1'b1;
      else if (blink_tick) phase_q <= ~phase_q;
   end

   assign blank_blink = !phase_q && act_buf.blink[idx];
`else
   assign blank_blink = 1'b0;
`endif

   always_comb begin
      nib   = act_buf.digits[{idx, 2'b00} +: 4];
      lit   = act_buf.digit_en[idx] && !blank_blink;
      an_nx = SEG_BLANK;
      dc_nx = SEG_BLANK;
      if (lit) begin
         an_nx = ~(8'h01 << idx);
         dc_nx = {seg_decode(nib), ~act_buf.dp[idx]};
      end
   end

   // The tick edge moves idx and blanks the outputs for one cycle so the old
   // digit's cathodes never show on the new anode.
   always_ff @(posedge clock) begin
      if (reset || scan_tick) begin
         an      <= SEG_BLANK;
         dec_cat <= SEG_BLANK;
      end else begin
         an      <= an_nx;
         dec_cat <= dc_nx;
      end
   end

endmodule

// File: tb/tb_display_7seg_mux.sv
// Self-checking bench for display_7seg_mux with SCAN_CONT=4 (32-cycle frame).
// Expected frames are pushed when an update is driven and popped at frame_sync.
module tb_display_7seg_mux;
   import display_pkg::*;

   localparam int SC    = 4;
   localparam int FRAME = SC * 8;

   typedef struct packed {
      logic [7:0][7:0] an;
      logic [7:0][7:0] dc;
   } frame_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] an, dec_cat;

   display_7seg_mux_if bus();

   display_7seg_mux #(
      .SCAN_CONT(SC)
`ifdef DISPLAY_BLINK_EN
      , .BLINK_CONT(64)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .an(an),
      .dec_cat(dec_cat)
   );

   always #5 clock = ~clock;

   int     vectors = 0;
   int     miscompares = 0;
   frame_t exp_q[$];
   frame_t cur;
   logic   pend_flag;

   // Reference abcdefg patterns, active high.
   function automatic logic [6:0] seg_ref(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;  default: return 7'b1000111;
      endcase
   endfunction

   function automatic frame_t mk_frame(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
      frame_t f;
      for (int i = 0; i < 8; i++) begin
         if (en[i]) begin
            f.an[i] = ~(8'h01 << i);
            f.dc[i] = {~seg_ref(d[4*i +: 4]), ~p[i]};
         end else begin
            f.an[i] = 8'hFF;
            f.dc[i] = 8'hFF;
         end
      end
      return f;
   endfunction

   task automatic do_update(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
      frame_t f;
      bus.digits   = d;
      bus.digit_en = en;
      bus.dp       = p;
      bus.update   = 1'b1;
      f = mk_frame(d, en, p);
      if (pend_flag) exp_q[exp_q.size()-1] = f;
      else begin
         exp_q.push_back(f);
         pend_flag = 1'b1;
      end
   endtask

   task automatic wait_fs();
      bit found = 0;
      for (int n = 0; n < 3*FRAME; n++) begin
         if (bus.frame_sync === 1'b1) begin
            found = 1;
            break;
         end
         vectors++;
         if (bus.pending !== pend_flag) begin
            miscompares++;
            $display("FAIL pending_wait got %b exp %b", bus.pending, pend_flag);
         end
         @(negedge clock);
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL frame_sync_timeout got none exp pulse within %0d cycles", 3*FRAME);
      end
   endtask

   // Checks one whole frame starting at its frame_sync cycle; optionally
   // drives up to two updates at given frame offsets.
   task automatic check_frame(input int u1, input logic [31:0] d1, input logic [7:0] e1, input logic [7:0] p1,
                              input int u2, input logic [31:0] d2, input logic [7:0] e2, input logic [7:0] p2);
      logic [7:0] ea, ed;
      int d, k;
      if (pend_flag) begin
         cur = exp_q.pop_front();
         pend_flag = 1'b0;
      end
      for (int off = 0; off < FRAME; off++) begin
         d  = off / SC;
         k  = off % SC;
         ea = (k == 0) ? 8'hFF : cur.an[d];
         ed = (k == 0) ? 8'hFF : cur.dc[d];
         vectors += 4;
         if (an !== ea) begin
            miscompares++;
            $display("FAIL an off=%0d got %h exp %h", off, an, ea);
         end
         if (dec_cat !== ed) begin
            miscompares++;
            $display("FAIL dec_cat off=%0d got %h exp %h", off, dec_cat, ed);
         end
         if (bus.frame_sync !== (off == 0)) begin
            miscompares++;
            $display("FAIL frame_sync off=%0d got %b exp %b", off, bus.frame_sync, off == 0);
         end
         if (bus.pending !== pend_flag) begin
            miscompares++;
            $display("FAIL pending off=%0d got %b exp %b", off, bus.pending, pend_flag);
         end
         bus.update = 1'b0;
         if (off == u1) do_update(d1, e1, p1);
         if (off == u2) do_update(d2, e2, p2);
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.digits = '0; bus.digit_en = '0; bus.dp = '0; bus.update = 1'b0;
`ifdef DISPLAY_BLINK_EN
      bus.blink = '0;
`endif
      exp_q.delete(); pend_flag = 1'b0; cur = mk_frame(32'h0, 8'h00, 8'h00);
      repeat (3) @(negedge clock);
      vectors += 4;
      if (an !== 8'hFF)            begin miscompares++; $display("FAIL rst_an got %h exp FF", an); end
      if (dec_cat !== 8'hFF)       begin miscompares++; $display("FAIL rst_dec_cat got %h exp FF", dec_cat); end
      if (bus.pending !== 1'b0)    begin miscompares++; $display("FAIL rst_pending got %b exp 0", bus.pending); end
      if (bus.frame_sync !== 1'b0) begin miscompares++; $display("FAIL rst_frame_sync got %b exp 0", bus.frame_sync); end
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         vectors += 2;
         if (an !== 8'hFF)      begin miscompares++; $display("FAIL blank_an cyc=%0d got %h exp FF", i, an); end
         if (dec_cat !== 8'hFF) begin miscompares++; $display("FAIL blank_dec cyc=%0d got %h exp FF", i, dec_cat); end
      end
   endtask

   task automatic test_basic();
      do_update(32'h0000_0518, 8'h0F, 8'h00);
      @(negedge clock);
      bus.update = 1'b0;
      wait_fs();
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
   endtask

   task automatic test_midframe();
      check_frame(6, 32'h0000_0001, 8'h0F, 8'h00, -1, '0, '0, '0);
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
      check_frame(5, 32'h0000_0022, 8'h0F, 8'h00, 13, 32'h0000_ABCD, 8'hFF, 8'hA5);
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
   endtask

   task automatic test_dp();
      check_frame(3, 32'h0000_0000, 8'h01, 8'h01, -1, '0, '0, '0);
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
   endtask

   task automatic test_reset_mid();
      repeat (5) @(negedge clock);
      do_update(32'hFFFF_FFFF, 8'hFF, 8'hFF);
      @(negedge clock);
      bus.update = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete(); pend_flag = 1'b0; cur = mk_frame(32'h0, 8'h00, 8'h00);
      repeat (2) @(negedge clock);
      vectors += 2;
      if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL midrst_pending got %b exp 0", bus.pending); end
      if (an !== 8'hFF)         begin miscompares++; $display("FAIL midrst_an got %h exp FF", an); end
      reset = 1'b0;
      @(negedge clock);
      wait_fs();
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
      check_frame(-1, '0, '0, '0, -1, '0, '0, '0);
   endtask

`ifdef DISPLAY_BLINK_EN
   task automatic test_blink();
      int n_lit = 0, n_blank = 0, n_bad = 0, d, k;
      bus.blink = 8'h01;
      do_update(32'h0000_0018, 8'h03, 8'h00);
      @(negedge clock);
      bus.update = 1'b0;
      wait_fs();
      cur = exp_q.pop_front();
      pend_flag = 1'b0;
      for (int i = 0; i < 6*FRAME; i++) begin
         d = (i % FRAME) / SC;
         k = i % SC;
         if (k != 0) begin
            if (d == 0) begin
               if (an === 8'hFE && dec_cat === 8'h01) n_lit++;
               else if (an === 8'hFF && dec_cat === 8'hFF) n_blank++;
               else n_bad++;
            end else if (an !== cur.an[d] || dec_cat !== cur.dc[d]) n_bad++;
         end
         @(negedge clock);
      end
      vectors += 3;
      if (n_lit == 0)   begin miscompares++; $display("FAIL blink_lit got %0d exp >0", n_lit); end
      if (n_blank == 0) begin miscompares++; $display("FAIL blink_blank got %0d exp >0", n_blank); end
      if (n_bad != 0)   begin miscompares++; $display("FAIL blink_other got %0d exp 0", n_bad); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_midframe();
      test_dp();
      test_reset_mid();
`ifdef DISPLAY_BLINK_EN
      test_blink();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_7seg_mux.md
Name: display_7seg_mux

Overview:
- Consumer end of the timer's display interface: takes eight packed 4-bit digit codes from the timer or stopwatch logic and drives the multiplexed 8-digit 7-segment display through `an` and `dec_cat`.
- Time-multiplexes one digit at a time.
- Digit, enable and decimal-point data are double-buffered, so a display update lands only on a frame boundary and never tears mid-frame.

Parameters:
- SCAN_CONT, 50000, clock cycles each digit stays lit. 100 MHz gives a 2 kHz digit rate and a 250 Hz frame rate.
- NUM_DIG, 8, number of digits scanned. Fixed at 8; `an` and `dec_cat` are 8 bits wide.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- digits  input  32  digit codes; nibble i ([4i+3:4i]) is shown on digit i; values 0-F, hex
- digit_en  input  8  per-digit enable; 0 blanks that digit
- dp  input  8  per-digit decimal point; 1 lights it
- update  input  1  one-cycle strobe; captures digits, digit_en and dp into the pending buffer
- pending  output  1  high while captured data waits for the next frame boundary
- frame_sync  output  1  one-cycle pulse when the scan index wraps from 7 to 0
- an  output  8  anode selects, active low; an[i]=0 lights digit i
- dec_cat  output  8  cathodes, active low, ordered {a,b,c,d,e,f,g,dp}

Behaviour:
- Reset (synchronous, active-high):
  - scan counter = 0, scan index = 0.
  - pending and active buffers = 0, so all digits are disabled.
  - an = 8'hFF, dec_cat = 8'hFF, pending = 0, frame_sync = 0.
- Scan counter:
  - Counts 0..SCAN_CONT-1.
  - At SCAN_CONT-1 it returns to 0 and the scan index increments modulo 8 (7 wraps to 0).
- Frame boundary: the cycle in which the index goes 7→0.
  - frame_sync = 1 in the following cycle only.
  - If pending=1, the pending buffer is copied to the active buffer in that same edge, and pending clears.
- Update:
  - update=1 loads the pending buffer and sets pending=1.
  - A later update before the boundary overwrites it; the last one wins.
  - update coinciding with the boundary edge: the old pending data commits, the new data is captured, and pending stays 1.
  - update with pending=0 at the boundary edge: the data is captured only; it commits at the next boundary.
- Outputs are registered, one cycle after the scan index changes:
  - an = ~(8'h01 << idx) if active digit_en[idx] = 1, otherwise an = 8'hFF.
  - dec_cat[7:1] = ~seg(nibble idx). dec_cat[0] = ~dp[idx].
  - If digit_en[idx] = 0, dec_cat = 8'hFF.
- Segment decode is hex, abcdefg active-high before inversion:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
- Anti-ghosting: an = 8'hFF for exactly one cycle at each index change before the next digit is driven.
- Reset mid-frame: all state returns to reset values at the next edge; any pending update is discarded.
- SCAN_CONT < 2 is illegal; a simulation assertion flags it.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- When defined:
  - Adds input `blink[7:0]` and parameter BLINK_CONT, default 25_000_000.
  - blink is captured and committed together with digits.
  - A phase flip-flop toggles every BLINK_CONT cycles; reset value is 1.
  - While phase = 0, a digit with active blink[i]=1 is blanked (an bit 1, dec_cat 8'hFF).
  - frame_sync and commit timing are unchanged.
- When undefined: no blink port, no phase logic; behaviour is exactly as above.

Decomposition:
- Package display_pkg:
  - NUM_DIG.
  - SEG_BLANK = 8'hFF.
  - Function seg_decode(4-bit) returning active-low {a..g}.
  - Typedef disp_buf_t {digits, digit_en, dp[, blink]}.
- One sub-module, scan_div: parameterised terminal-count divider producing a one-cycle tick.
  - Used for the scan tick and, under DISPLAY_BLINK_EN, the blink tick.

Test Plan:
- SCAN_CONT=4; reset held 3 cycles → an=FF, dec_cat=FF, pending=0; after release all digits stay blank (digit_en=0).
- update with digits=32'h0000_0518, digit_en=8'h0F, dp=8'h00 → pending=1 until the first frame_sync; after it, digit0 shows an=FE, dec_cat=01 ("8"); digit1 an=FD, dec_cat=9F ("1"); digit2 an=FB, dec_cat=49 ("5"); digit3 an=F7, dec_cat=03 ("0"); digits 4-7 an=FF.
- Each digit lit for SCAN_CONT-1 cycles with an=FF in the one gap cycle → frame_sync period = 32 cycles.
- update mid-frame with digits=32'h0000_0001 → displayed value unchanged until the wrap; frame_sync and the new value appear together with pending falling; two updates in one frame → the last value is shown.
- dp=8'h01 on digit0 showing 0 → dec_cat=02; reset asserted mid-frame with an update pending → the pending data is never displayed.
- DISPLAY_BLINK_EN, BLINK_CONT=64, blink=8'h01 → digit0 alternately shown and blanked every 64 cycles; other digits unaffected.
